product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream stage of the 16x16 Wallace multiplier: consumes its 32-bit unsigned products over a
//  valid/ready stream and sums a programmed number of them into a wide accumulator (dot-product/MAC).
//  Result is offered on a valid/ready output held stable until taken; sticky overflow reported with it.
// PARAMETERS
//  PROD_W    32  width of incoming product (matches 16x16 multiplier result)
//  ACC_W     40  accumulator/result width; must be >= PROD_W
//  LEN_W     8   width of beat count; max burst = 2**LEN_W-1 products
//  SATURATE  0   0: accumulator wraps mod 2**ACC_W; 1: clamps at 2**ACC_W-1
// PORTS
//  clk         in   1       rising-edge clock, sole clock domain
//  rst         in   1       synchronous reset, active-high
//  start       in   1       begin burst; sampled only in IDLE
//  len         in   LEN_W   number of products in burst, captured with start
//  prod_valid  in   1       product beat valid
//  prod_data   in   PROD_W  unsigned product
//  prod_ready  out  1       stage accepts a beat this cycle
//  acc_valid   out  1       result valid
//  acc_data    out  ACC_W   accumulated sum
//  acc_ovf     out  1       sticky: sum exceeded 2**ACC_W-1 during burst
//  acc_ready   in   1       consumer takes result
//  busy        out  1       high in ACCUM or DONE
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, acc=0, remaining=0, ovf=0; prod_ready=0, acc_valid=0,
//   acc_data=0, acc_ovf=0, busy=0. Reset mid-burst or mid-DONE discards all progress; no partial output.
//  FSM  IDLE -> ACCUM on start with len!=0 (acc<=0, ovf<=0, remaining<=len).
//       IDLE -> DONE  on start with len==0 (acc<=0, ovf<=0); result 0 next cycle.
//       ACCUM -> DONE when beat accepted with remaining==1.
//       DONE -> IDLE when acc_valid && acc_ready.
//  start outside IDLE ignored; len sampled only with accepted start.
//  prod_ready = (state==ACCUM), purely state-based (no combinational path from prod_valid/acc_ready).
//  Beat accepted iff prod_valid && prod_ready; at that edge acc<=acc+zero-extended prod_data,
//   remaining<=remaining-1. prod_valid with prod_ready=0 is not consumed; upstream must hold data.
//  Overflow: carry out of ACC_W bits sets ovf (sticky for burst). SATURATE=0: acc keeps low ACC_W
//   bits. SATURATE=1: acc<=all-ones and stays there for rest of burst.
//  acc_valid = (state==DONE); acc_data/acc_ovf registered, stable while acc_valid && !acc_ready.
//  Latency: acc_valid rises the cycle after the last beat is accepted; no gaps required between beats
//   (one beat per cycle sustained). New start accepted no earlier than the cycle after result handshake.
//  acc_data/acc_ovf keep last value in IDLE (not cleared until next start).
// STRUCTURE
//  Shared package: state enum {IDLE, ACCUM, DONE} (2-bit), default width constants PROD_W/ACC_W.
//  One sub-module: acc_adder (ACC_W-bit adder, carry out, SATURATE param) -> sum, ovf; kept
//   combinational and separate so it can later be replaced by a carry-save/pipelined form.
//  Top holds FSM, remaining counter, acc/ovf registers, handshake logic.
// TESTING
//  1 start,len=3; products 6,20,100 back-to-back -> acc_valid 1 cycle after 3rd beat, acc_data=126, acc_ovf=0.
//  2 start,len=0 -> next cycle acc_valid=1, acc_data=0; prod_valid=1 meanwhile never sees prod_ready.
//  3 len=2, products 32'hFFFF_FFFF x2 with ACC_W=32: SATURATE=0 -> acc_data=32'hFFFF_FFFE, acc_ovf=1;
//    SATURATE=1 -> acc_data=32'hFFFF_FFFF, acc_ovf=1. Default ACC_W=40 -> 40'h1_FFFF_FFFE, acc_ovf=0.
//  4 len=4 with random prod_valid gaps and acc_ready low 5 cycles -> sum correct, acc_data stable
//    while stalled, busy high throughout, start pulses during burst/DONE ignored.
//  5 rst asserted after 2 of 4 beats -> next cycle IDLE, all outputs 0; fresh len=1, product 7 -> acc_data=7.
//  6 Product stream from wallace multiplier (a=16'hFFFF,b=16'hFFFF; a=3,b=5) len=2 -> acc_data=40'hFFFE_0010.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator stage.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DFLT_PROD_W = 32;
  localparam int DFLT_ACC_W  = 40;

endpackage

// File: rtl/product_accumulator_acc.sv
// Combinational accumulate step: acc + zero-extended product, with carry-out and optional clamp.
module acc_adder #(
  parameter int PROD_W   = 32,
  parameter int ACC_W    = 40,
  parameter bit SATURATE = 1'b0
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, acc} + (ACC_W+1)'(prod);
    ovf  = full[ACC_W];
    // Clamping forces all-ones; later beats carry again and keep it pinned there.
    if (SATURATE && full[ACC_W]) sum = '1;
    else                         sum = full[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products into a wide accumulator and offers the result.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds data stable until then.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W   = DFLT_PROD_W,
  parameter int ACC_W    = DFLT_ACC_W,
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf,
  input  logic              acc_ready,
  output logic              busy,
  output state_t            dbg_state
);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   remaining;
  logic               ovf;
  logic [ACC_W-1:0]   sum;
  logic               sum_ovf;
  logic               beat;

  acc_adder #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_adder (
    .acc  (acc),
    .prod (prod_data),
    .sum  (sum),
    .ovf  (sum_ovf)
  );

  // Ready depends only on state so no combinational path runs back to the producer.
  assign prod_ready = (state == ACCUM);
  assign beat       = prod_valid && prod_ready;
  assign acc_valid  = (state == DONE);
  assign acc_data   = acc;
  assign acc_ovf    = ovf;
  assign busy       = (state == ACCUM) || (state == DONE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (beat && remaining == LEN_W'(1)) state_nxt = DONE;
      DONE:    if (acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc       <= '0;
        ovf       <= 1'b0;
        remaining <= len;
      end else if (beat) begin
        acc       <= sum;
        ovf       <= ovf | sum_ovf;
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default build plus two 32-bit builds (wrap and clamp).
module tb_product_accumulator;
  import product_accumulator_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [31:0] prod_data;
  logic        acc_ready;

  logic        prod_ready, acc_valid, acc_ovf, busy;
  logic [39:0] acc_data;
  state_t      dbg_state;

  logic        w_prod_ready, w_acc_valid, w_acc_ovf, w_busy;
  logic [31:0] w_acc_data;
  state_t      w_dbg_state;
  logic        s_prod_ready, s_acc_valid, s_acc_ovf, s_busy;
  logic [31:0] s_acc_data;
  state_t      s_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ovf(acc_ovf),
    .acc_ready(acc_ready), .busy(busy), .dbg_state(dbg_state)
  );

  product_accumulator #(.ACC_W(32), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(w_prod_ready),
    .acc_valid(w_acc_valid), .acc_data(w_acc_data), .acc_ovf(w_acc_ovf),
    .acc_ready(acc_ready), .busy(w_busy), .dbg_state(w_dbg_state)
  );

  product_accumulator #(.ACC_W(32), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(s_prod_ready),
    .acc_valid(s_acc_valid), .acc_data(s_acc_data), .acc_ovf(s_acc_ovf),
    .acc_ready(acc_ready), .busy(s_busy), .dbg_state(s_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_burst(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  // Presents one beat and holds it until the stage takes it.
  task automatic send_beat(input logic [31:0] d);
    bit accepted = 1'b0;
    prod_valid = 1'b1;
    prod_data  = d;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (prod_ready) accepted = 1'b1;
      tick();
    end
    if (!accepted) check_eq("beat_timeout", {63'd0, prod_ready}, 64'd1);
  endtask

  task automatic check_result(input string tag, input logic exp_ovf);
    logic [39:0] exp;
    exp = exp_q.pop_front();
    check_eq({tag, "_valid"}, {63'd0, acc_valid}, 64'd1);
    check_eq({tag, "_data"}, {24'd0, acc_data}, {24'd0, exp});
    check_eq({tag, "_ovf"}, {63'd0, acc_ovf}, {63'd0, exp_ovf});
  endtask

  task automatic take_result();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    logic [39:0] held;
    logic [31:0] p0, p1;
    logic [15:0] ma, mb;

    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod_data = '0; acc_ready = 1'b0;
    tick(); tick();
    check_eq("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    check_eq("rst_outs", {60'd0, prod_ready, acc_valid, acc_ovf, busy}, 64'd0);
    check_eq("rst_data", {24'd0, acc_data}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: three back-to-back beats
    start_burst(8'd3);
    check_eq("t1_ready", {63'd0, prod_ready}, 64'd1);
    send_beat(32'd6);
    send_beat(32'd20);
    check_eq("t1_early_valid", {63'd0, acc_valid}, 64'd0);
    send_beat(32'd100);
    prod_valid = 1'b0;
    exp_q.push_back(40'd126);
    check_result("t1", 1'b0);
    check_eq("t1_ready_done", {63'd0, prod_ready}, 64'd0);
    take_result();
    check_eq("t1_idle_valid", {63'd0, acc_valid}, 64'd0);
    check_eq("t1_idle_hold", {24'd0, acc_data}, 64'd126);

    // 2: zero-length burst while a beat is offered
    prod_valid = 1'b1;
    prod_data  = 32'd55;
    start_burst(8'd0);
    exp_q.push_back(40'd0);
    check_result("t2", 1'b0);
    check_eq("t2_no_ready", {63'd0, prod_ready}, 64'd0);
    check_eq("t2_busy", {63'd0, busy}, 64'd1);
    tick();
    check_eq("t2_no_ready2", {63'd0, prod_ready}, 64'd0);
    prod_valid = 1'b0;
    take_result();

    // 3: overflow behaviour in all three builds
    start_burst(8'd2);
    send_beat(32'hFFFF_FFFF);
    send_beat(32'hFFFF_FFFF);
    prod_valid = 1'b0;
    exp_q.push_back(40'h1_FFFF_FFFE);
    check_result("t3_def", 1'b0);
    check_eq("t3_wrap_data", {32'd0, w_acc_data}, 64'hFFFF_FFFE);
    check_eq("t3_wrap_ovf", {63'd0, w_acc_ovf}, 64'd1);
    check_eq("t3_sat_data", {32'd0, s_acc_data}, 64'hFFFF_FFFF);
    check_eq("t3_sat_ovf", {63'd0, s_acc_ovf}, 64'd1);
    take_result();

    // 4: gaps between beats, stray starts, stalled consumer
    start_burst(8'd4);
    foreach (p0[i]) begin end
    for (int k = 0; k < 4; k++) begin
      int gap = $urandom_range(0, 3);
      prod_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        start = 1'b1;
        len   = 8'd9;
        tick();
        check_eq("t4_busy_gap", {63'd0, busy}, 64'd1);
      end
      start = 1'b0;
      case (k)
        0: send_beat(32'd10);
        1: send_beat(32'd200);
        2: send_beat(32'd3000);
        default: send_beat(32'd40000);
      endcase
    end
    prod_valid = 1'b0;
    exp_q.push_back(40'd43210);
    check_result("t4", 1'b0);
    held = acc_data;
    start = 1'b1;
    len   = 8'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("t4_stall_valid", {63'd0, acc_valid}, 64'd1);
      check_eq("t4_stall_data", {24'd0, acc_data}, {24'd0, held});
      check_eq("t4_stall_busy", {63'd0, busy}, 64'd1);
    end
    start = 1'b0;
    take_result();
    check_eq("t4_back_idle", {62'd0, dbg_state}, {62'd0, IDLE});
    check_eq("t4_hold_data", {24'd0, acc_data}, 64'd43210);

    // 5: reset mid-burst discards progress
    start_burst(8'd4);
    send_beat(32'd1);
    send_beat(32'd2);
    prod_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_state", {62'd0, dbg_state}, {62'd0, IDLE});
    check_eq("t5_outs", {60'd0, prod_ready, acc_valid, acc_ovf, busy}, 64'd0);
    check_eq("t5_data", {24'd0, acc_data}, 64'd0);
    start_burst(8'd1);
    send_beat(32'd7);
    prod_valid = 1'b0;
    exp_q.push_back(40'd7);
    check_result("t5", 1'b0);
    take_result();

    // 6: products as produced by the 16x16 multiplier
    ma = 16'hFFFF; mb = 16'hFFFF; p0 = ma * mb;
    ma = 16'd3;    mb = 16'd5;    p1 = ma * mb;
    start_burst(8'd2);
    send_beat(p0);
    send_beat(p1);
    prod_valid = 1'b0;
    exp_q.push_back(40'hFFFE_0010);
    check_result("t6", 1'b0);
    take_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
